// File: rtl/llc_read_arbiter_pkg.sv
// Shared types and the round-robin pick for the LLC line-fill read arbiter.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package llc_arb_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, RESP, GAP} arb_state_t;

  typedef enum logic {REQ_I, REQ_D} req_id_t;

  // 64-byte lines: the low address bits select a byte within the line
  localparam int LINE_OFFSET_BITS = 6;

  // Two-way round robin: a lone requester always wins; on a tie the
  // requester that did not win last time goes first.
  function automatic req_id_t rr_pick2(input logic vld_i, input logic vld_d,
                                       input req_id_t last);
    req_id_t pick;
    pick = REQ_I;
    if (vld_i && vld_d) begin
      pick = (last == REQ_I) ? REQ_D : REQ_I;
    end else if (vld_d) begin
      pick = REQ_D;
    end
    return pick;
  endfunction

endpackage

// File: rtl/llc_read_arbiter_if.sv
// Bundle of the two L1 miss read channels and the LLC read channel.
// Latency: n/a (wires only).
// Backpressure: requests are level-held until a data pulse or withdrawal.
interface llc_read_arbiter_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int LINE_BITS  = 512
) ();

  logic [ADDR_WIDTH-1:0] S1_R_ADDR;
  logic                  S1_R_ADDR_VALID;
  logic [LINE_BITS-1:0]  S1_R_DATA;
  logic                  S1_R_DATA_VALID;

  logic [ADDR_WIDTH-1:0] S2_R_ADDR;
  logic                  S2_R_ADDR_VALID;
  logic [LINE_BITS-1:0]  S2_R_DATA;
  logic                  S2_R_DATA_VALID;

  logic [ADDR_WIDTH-1:0] M_R_ADDR;
  logic                  M_R_ADDR_VALID;
  logic [LINE_BITS-1:0]  M_R_DATA;
  logic                  M_R_DATA_VALID;

  // Arbiter side: takes requests from the L1s and data from the LLC
  modport slave (
    input  S1_R_ADDR, S1_R_ADDR_VALID, S2_R_ADDR, S2_R_ADDR_VALID,
    input  M_R_DATA, M_R_DATA_VALID,
    output S1_R_DATA, S1_R_DATA_VALID, S2_R_DATA, S2_R_DATA_VALID,
    output M_R_ADDR, M_R_ADDR_VALID
  );

  // Environment side: the L1 miss paths and the LLC read port
  modport master (
    output S1_R_ADDR, S1_R_ADDR_VALID, S2_R_ADDR, S2_R_ADDR_VALID,
    output M_R_DATA, M_R_DATA_VALID,
    input  S1_R_DATA, S1_R_DATA_VALID, S2_R_DATA, S2_R_DATA_VALID,
    input  M_R_ADDR, M_R_ADDR_VALID
  );

endinterface

// File: rtl/llc_read_arbiter.sv
// Round-robin share of the LLC line-fill read port between L1-I and L1-D.
// Latency: grant -> LLC request next cycle; LLC data -> L1 data pulse next cycle.
// Backpressure: one line read in flight; other requests wait for the next IDLE.
module llc_read_arbiter
  import llc_arb_pkg::*;
#(
  parameter int ADDR_WIDTH     = 64,
  parameter int LINE_BITS      = 512,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic              clk,
  input  logic              reset,
  llc_read_arbiter_if.slave bus,
  output logic              ERR
);

  localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TIMER_W-1:0] TIMER_MAX = TIMER_W'(TIMEOUT_CYCLES);
  localparam logic [ADDR_WIDTH-1:0] OFFSET_MASK =
    ADDR_WIDTH'((64'd1 << LINE_OFFSET_BITS) - 64'd1);

  arb_state_t            state;
  arb_state_t            state_nxt;
  req_id_t               last_grant;
  req_id_t               winner;
  req_id_t               pick;
  logic                  grant;
  logic                  winner_vld;
  logic                  drop;
  logic                  err_q;
  logic [ADDR_WIDTH-1:0] pick_addr;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LINE_BITS-1:0]  line_q;
  logic [TIMER_W-1:0]    timer;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state, arbitration pick and the current winner's request level
  always_comb begin
    state_nxt  = state;
    grant      = 1'b0;
    pick       = rr_pick2(bus.S1_R_ADDR_VALID, bus.S2_R_ADDR_VALID, last_grant);
    pick_addr  = (pick == REQ_I) ? bus.S1_R_ADDR : bus.S2_R_ADDR;
    winner_vld = (winner == REQ_I) ? bus.S1_R_ADDR_VALID : bus.S2_R_ADDR_VALID;
    case (state)
      IDLE: begin
        if (bus.S1_R_ADDR_VALID || bus.S2_R_ADDR_VALID) begin
          grant     = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (bus.M_R_DATA_VALID) begin
          state_nxt = RESP;
        end
      end
      RESP:    state_nxt = GAP;
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Transaction context: grant bookkeeping, withdraw tracking, timeout and line capture
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant <= REQ_D;
      winner     <= REQ_I;
      drop       <= 1'b0;
      addr_q     <= '0;
      line_q     <= '0;
      timer      <= '0;
      err_q      <= 1'b0;
    end else begin
      if (grant) begin
        last_grant <= pick;
        winner     <= pick;
        addr_q     <= pick_addr & ~OFFSET_MASK;
        drop       <= 1'b0;
        timer      <= '0;
      end
      if (state == BUSY) begin
        if (timer != TIMER_MAX) begin
          timer <= timer + TIMER_W'(1);
        end
        if (timer == TIMER_MAX) begin
          err_q <= 1'b1;
        end
        // A withdrawn winner still lets the LLC read finish; the line is just not delivered
        if (!winner_vld) begin
          drop <= 1'b1;
        end
        if (bus.M_R_DATA_VALID) begin
          line_q <= bus.M_R_DATA;
        end
      end
    end
  end

  assign bus.M_R_ADDR        = addr_q;
  assign bus.M_R_ADDR_VALID  = (state == BUSY);
  assign bus.S1_R_DATA       = line_q;
  assign bus.S2_R_DATA       = line_q;
  assign bus.S1_R_DATA_VALID = (state == RESP) && (winner == REQ_I) && !drop;
  assign bus.S2_R_DATA_VALID = (state == RESP) && (winner == REQ_D) && !drop;
  assign ERR                 = err_q;

endmodule

// File: tb/tb_llc_read_arbiter.sv
// Bench for llc_read_arbiter: directed table, hand sequences and random traffic
// checked every cycle against a transaction-level reference model.
module tb_llc_read_arbiter;

  localparam int AW = 64;
  localparam int LB = 512;
  localparam int TMO = 16;
  localparam logic [AW-1:0] I_ADDR = 64'h0000_0000_1000_0044;
  localparam logic [AW-1:0] D_ADDR = 64'h0000_0000_2000_0008;
  localparam logic [AW-1:0] I_LINE = 64'h0000_0000_1000_0040;
  localparam logic [AW-1:0] D_LINE = 64'h0000_0000_2000_0000;

  logic clk;
  logic reset;
  logic err;

  llc_read_arbiter_if #(.ADDR_WIDTH(AW), .LINE_BITS(LB)) bus ();

  llc_read_arbiter #(.ADDR_WIDTH(AW), .LINE_BITS(LB), .TIMEOUT_CYCLES(TMO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .ERR   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: one line read in flight, described by event edges
  int            edge_n = 0;
  bit            m_out;
  int            m_owner;     // 0 = L1-I, 1 = L1-D
  int            m_last;
  bit            m_drop;
  int            m_busy_edges;
  int            m_pulse_at;
  int            m_free_at;
  bit            m_err;
  logic [AW-1:0] m_addr;
  logic [LB-1:0] m_line;

  // Stimulus-side bookkeeping
  int            mav_age = 0;
  logic          prev_mav = 1'b0;
  bit            mav_rise = 1'b0;
  int            s1_pulses = 0;
  int            s2_pulses = 0;
  bit            auto_release = 1'b1;
  bit            spurious = 1'b0;
  logic [AW-1:0] rise_addr[$];

  typedef struct {
    logic          s1v;
    logic [AW-1:0] s1a;
    logic          mdv;
    logic [LB-1:0] md;
    logic          e_mav;
    logic [AW-1:0] e_maddr;
    logic          e_s1v;
    logic          e_s2v;
    logic [LB-1:0] e_data;
  } vec_t;

  vec_t tbl[10];

  task automatic check(input string name, input logic [LB-1:0] act, input logic [LB-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_out = 0; m_owner = 0; m_last = 1; m_drop = 0; m_busy_edges = 0;
    m_pulse_at = -1; m_free_at = 0; m_err = 0; m_addr = '0; m_line = '0;
  endtask

  task automatic model_step(input logic v1, input logic [AW-1:0] a1,
                            input logic v2, input logic [AW-1:0] a2,
                            input logic mv, input logic [LB-1:0] md);
    edge_n++;
    if (!m_out) begin
      if (edge_n >= m_free_at && (v1 || v2)) begin
        if (v1 && v2) m_owner = (m_last == 0) ? 1 : 0;
        else          m_owner = v1 ? 0 : 1;
        m_last = m_owner;
        m_out = 1;
        m_addr = (m_owner == 0 ? a1 : a2) & ~64'h3f;
        m_drop = 0;
        m_busy_edges = 0;
      end
    end else begin
      m_busy_edges++;
      if (m_busy_edges >= TMO + 1) m_err = 1;
      if (!(m_owner == 0 ? v1 : v2)) m_drop = 1;
      if (mv) begin
        m_out = 0;
        m_line = md;
        if (!m_drop) m_pulse_at = edge_n;
        m_free_at = edge_n + 3;
      end
    end
  endtask

  task automatic check_outputs();
    check("m_addr_valid", bus.M_R_ADDR_VALID, m_out);
    check("m_addr", bus.M_R_ADDR, m_addr);
    check("s1_data_valid", bus.S1_R_DATA_VALID, (m_pulse_at == edge_n && m_owner == 0));
    check("s2_data_valid", bus.S2_R_DATA_VALID, (m_pulse_at == edge_n && m_owner == 1));
    check("s1_data", bus.S1_R_DATA, m_line);
    check("s2_data", bus.S2_R_DATA, m_line);
    check("err", err, m_err);
  endtask

  // One clock: model advances on the edge with the inputs held before it
  task automatic cycle();
    logic          v1, v2, mv;
    logic [AW-1:0] a1, a2;
    logic [LB-1:0] md;
    v1 = bus.S1_R_ADDR_VALID; a1 = bus.S1_R_ADDR;
    v2 = bus.S2_R_ADDR_VALID; a2 = bus.S2_R_ADDR;
    mv = bus.M_R_DATA_VALID;  md = bus.M_R_DATA;
    @(posedge clk);
    if (!reset) model_reset();
    else        model_step(v1, a1, v2, a2, mv, md);
    #1;
    check_outputs();
  endtask

  task automatic observe();
    mav_rise = bus.M_R_ADDR_VALID && !prev_mav;
    if (mav_rise) rise_addr.push_back(bus.M_R_ADDR);
    prev_mav = bus.M_R_ADDR_VALID;
    mav_age = bus.M_R_ADDR_VALID ? mav_age + 1 : 0;
    if (bus.S1_R_DATA_VALID) begin
      s1_pulses++;
      if (auto_release) bus.S1_R_ADDR_VALID = 1'b0;
    end
    if (bus.S2_R_DATA_VALID) begin
      s2_pulses++;
      if (auto_release) bus.S2_R_ADDR_VALID = 1'b0;
    end
  endtask

  // LLC responds once the request has been visible for lat+1 cycles; lat<0 keeps it silent
  task automatic tick(input int lat);
    bus.M_R_DATA = {16{$urandom}};
    bus.M_R_DATA_VALID = 1'b0;
    if (bus.M_R_ADDR_VALID && lat >= 0 && mav_age >= lat + 1) bus.M_R_DATA_VALID = 1'b1;
    else if (spurious && !bus.M_R_ADDR_VALID && $urandom_range(0, 7) == 0) bus.M_R_DATA_VALID = 1'b1;
    cycle();
    observe();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    model_reset();
    check_outputs();
    tick(-1);
    tick(-1);
    reset = 1'b1;
  endtask

  task automatic clear_reqs();
    bus.S1_R_ADDR_VALID = 1'b0;
    bus.S2_R_ADDR_VALID = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    int p0, p1, p2, wait_cnt, rlat;
    reset = 1'b1;
    bus.S1_R_ADDR = I_ADDR; bus.S2_R_ADDR = D_ADDR;
    clear_reqs();
    bus.M_R_DATA_VALID = 1'b0; bus.M_R_DATA = '0;
    model_reset();

    // Single L1-I read: request, LLC answers in cycle 6, pulse in cycle 7 only
    for (int c = 0; c < 10; c++) begin
      tbl[c].s1v     = (c <= 7);
      tbl[c].s1a     = I_ADDR;
      tbl[c].mdv     = (c == 6);
      tbl[c].md      = (c == 6) ? {64{8'hA5}} : '0;
      tbl[c].e_mav   = (c <= 5);
      tbl[c].e_maddr = I_LINE;
      tbl[c].e_s1v   = (c == 6);
      tbl[c].e_s2v   = 1'b0;
      tbl[c].e_data  = (c >= 6) ? {64{8'hA5}} : '0;
    end

    do_reset();
    for (int c = 0; c < 10; c++) begin
      bus.S1_R_ADDR_VALID = tbl[c].s1v;
      bus.S1_R_ADDR       = tbl[c].s1a;
      bus.S2_R_ADDR_VALID = 1'b0;
      bus.M_R_DATA_VALID  = tbl[c].mdv;
      bus.M_R_DATA        = tbl[c].md;
      cycle();
      observe();
      check("tbl_mav", bus.M_R_ADDR_VALID, tbl[c].e_mav);
      check("tbl_maddr", bus.M_R_ADDR, tbl[c].e_maddr);
      check("tbl_s1v", bus.S1_R_DATA_VALID, tbl[c].e_s1v);
      check("tbl_s2v", bus.S2_R_DATA_VALID, tbl[c].e_s2v);
      check("tbl_data", bus.S1_R_DATA, tbl[c].e_data);
    end

    // Continuous dual requests from reset alternate I, D, I, D
    clear_reqs();
    do_reset();
    auto_release = 1'b0;
    rise_addr.delete();
    bus.S1_R_ADDR = I_ADDR; bus.S2_R_ADDR = D_ADDR;
    bus.S1_R_ADDR_VALID = 1'b1; bus.S2_R_ADDR_VALID = 1'b1;
    for (int i = 0; i < 80 && rise_addr.size() < 4; i++) tick(2);
    check("t2_grant_count", rise_addr.size(), 4);
    if (rise_addr.size() >= 4) begin
      check("t2_grant0", rise_addr[0], I_LINE);
      check("t2_grant1", rise_addr[1], D_LINE);
      check("t2_grant2", rise_addr[2], I_LINE);
      check("t2_grant3", rise_addr[3], D_LINE);
    end
    clear_reqs();
    auto_release = 1'b1;
    repeat (8) tick(0);

    // D raised while I is busy waits; its address appears 3 cycles after the I pulse
    bus.S1_R_ADDR_VALID = 1'b1;
    for (int i = 0; i < 10 && mav_age < 2; i++) tick(4);
    bus.S2_R_ADDR_VALID = 1'b1;
    p0 = s1_pulses;
    for (int i = 0; i < 40 && s1_pulses == p0; i++) tick(4);
    check("t3_s1_served", s1_pulses - p0, 1);
    rise_addr.delete();
    wait_cnt = 0;
    for (int i = 0; i < 10 && rise_addr.size() == 0; i++) begin
      tick(4);
      wait_cnt++;
    end
    check("t3_d_rise", rise_addr.size(), 1);
    check("t3_d_gap", wait_cnt, 3);
    if (rise_addr.size() > 0) check("t3_d_addr", rise_addr[0], D_LINE);
    p2 = s2_pulses;
    for (int i = 0; i < 40 && s2_pulses == p2; i++) tick(4);
    check("t3_s2_served", s2_pulses - p2, 1);
    repeat (4) tick(0);

    // I withdraws 2 cycles into BUSY: read still completes, no I pulse, D served after
    bus.S1_R_ADDR_VALID = 1'b1;
    for (int i = 0; i < 10 && mav_age < 2; i++) tick(5);
    bus.S1_R_ADDR_VALID = 1'b0;
    bus.S2_R_ADDR_VALID = 1'b1;
    p1 = s1_pulses; p2 = s2_pulses;
    for (int i = 0; i < 60 && s2_pulses == p2; i++) tick(5);
    check("t4_no_s1_pulse", s1_pulses - p1, 0);
    check("t4_s2_pulse", s2_pulses - p2, 1);
    repeat (4) tick(0);

    // Random traffic: withdrawals, varying LLC latency, stray LLC pulses
    spurious = 1'b1;
    rlat = 2;
    for (int i = 0; i < 400; i++) begin
      if (!bus.S1_R_ADDR_VALID) begin
        if ($urandom_range(0, 2) == 0) begin
          bus.S1_R_ADDR_VALID = 1'b1; bus.S1_R_ADDR = {$urandom, $urandom};
        end
      end else if ($urandom_range(0, 9) == 0) bus.S1_R_ADDR_VALID = 1'b0;
      if (!bus.S2_R_ADDR_VALID) begin
        if ($urandom_range(0, 2) == 0) begin
          bus.S2_R_ADDR_VALID = 1'b1; bus.S2_R_ADDR = {$urandom, $urandom};
        end
      end else if ($urandom_range(0, 9) == 0) bus.S2_R_ADDR_VALID = 1'b0;
      if (mav_rise) rlat = $urandom_range(0, 6);
      tick(rlat);
    end
    spurious = 1'b0;
    clear_reqs();
    repeat (10) tick(0);

    // LLC silent: ERR sets once the timer has reached the limit and stays set
    bus.S1_R_ADDR = I_ADDR;
    bus.S1_R_ADDR_VALID = 1'b1;
    rise_addr.delete();
    for (int i = 0; i < 10 && rise_addr.size() == 0; i++) tick(-1);
    check("t5_granted", rise_addr.size(), 1);
    repeat (TMO) tick(-1);
    check("t5_err_before", err, 1'b0);
    tick(-1);
    check("t5_err_set", err, 1'b1);
    p0 = s1_pulses;
    tick(0);
    check("t5_late_pulse", s1_pulses - p0, 1);
    tick(-1);
    tick(-1);
    check("t5_err_sticky", err, 1'b1);
    repeat (2) tick(-1);

    // Reset mid-BUSY clears outputs at once; afterwards a dual request grants I
    auto_release = 1'b0;
    bus.S1_R_ADDR = I_ADDR; bus.S2_R_ADDR = D_ADDR;
    bus.S1_R_ADDR_VALID = 1'b1; bus.S2_R_ADDR_VALID = 1'b1;
    for (int i = 0; i < 10 && mav_age < 3; i++) tick(-1);
    check("t6_busy", bus.M_R_ADDR_VALID, 1'b1);
    #3;
    reset = 1'b0;
    #1;
    model_reset();
    check_outputs();
    check("t6_mav_async", bus.M_R_ADDR_VALID, 1'b0);
    check("t6_err_async", err, 1'b0);
    tick(-1);
    tick(-1);
    reset = 1'b1;
    rise_addr.delete();
    tick(-1);
    check("t6_regrant", rise_addr.size(), 1);
    if (rise_addr.size() > 0) check("t6_first_i", rise_addr[0], I_LINE);
    clear_reqs();
    repeat (6) tick(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
